// File: rtl/reg_write_scheduler.sv
// Register-file write-port scheduler: merges in-order WB writes with buffered
// long-latency results, drives a registered write stage, and exposes forwarding lookups.
module reg_write_scheduler #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_we,
    input  logic [4:0]                 wb_reg,
    input  logic [31:0]                wb_data,
    input  logic                       mu_valid,
    input  logic [4:0]                 mu_reg,
    input  logic [31:0]                mu_data,
    output logic                       mu_ready,
    output logic                       RegWrite,
    output logic [4:0]                 WriteReg,
    output logic [31:0]                WriteData,
    input  logic [4:0]                 fwd_reg1,
    input  logic [4:0]                 fwd_reg2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [31:0]                fwd_data1,
    output logic [31:0]                fwd_data2,
    output logic                       pipe_stall,
    output logic [$clog2(DEPTH+1)-1:0] pending_cnt
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    logic [4:0]       ent_reg_q  [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [DEPTH-1:0] ent_live_q, ent_live_d;
    logic [PW-1:0]    rptr_q, wptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             stall_q, stall_d, pop_q;
    logic             we_q, we_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic wb_issue, fifo_empty, push, pop, head_live;

    assign wb_issue   = wb_we && (wb_reg != 5'd0);
    assign fifo_empty = (cnt_q == '0);
    assign mu_ready   = (cnt_q < CW'(DEPTH));
    // mu_reg=0 results are handshaken but never stored.
    assign push       = mu_valid && mu_ready && (mu_reg != 5'd0);
    assign pop        = !wb_issue && !fifo_empty;
    assign head_live  = ent_live_q[rptr_q];

    always_comb begin
        ent_live_d = ent_live_q;
        if (wb_issue) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ent_reg_q[i] == wb_reg) ent_live_d[i] = 1'b0;
            end
        end
        if (pop) ent_live_d[rptr_q] = 1'b0;
        // A same-cycle MU result is older than the WB write, so it arrives already dead.
        if (push) ent_live_d[wptr_q] = !(wb_issue && (mu_reg == wb_reg));
    end

    always_comb begin
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (wb_issue) begin
            we_d    = 1'b1;
            waddr_d = wb_reg;
            wdata_d = wb_data;
        end else if (pop && head_live) begin
            we_d    = 1'b1;
            waddr_d = ent_reg_q[rptr_q];
            wdata_d = ent_data_q[rptr_q];
        end

        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (wait_q < WW'(MAX_WAIT)) begin
            wait_d = wait_q + WW'(1);
        end else begin
            wait_d = wait_q;
        end

        // Stall drops one edge after the pop that relieved it.
        if (wait_d == WW'(MAX_WAIT)) begin
            stall_d = 1'b1;
        end else if (pop_q) begin
            stall_d = 1'b0;
        end else begin
            stall_d = stall_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_live_q <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            stall_q    <= 1'b0;
            pop_q      <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            ent_live_q <= ent_live_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            stall_q    <= stall_d;
            pop_q      <= pop;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Payload storage needs no reset; liveness gates every use.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_reg_q[wptr_q]  <= mu_reg;
            ent_data_q[wptr_q] <= mu_data;
        end
    end

    logic [4:0]  fa [2];
    logic        fh [2];
    logic [31:0] fd [2];

    assign fa[0] = fwd_reg1;
    assign fa[1] = fwd_reg2;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            fh[p] = 1'b0;
            fd[p] = '0;
            if (fa[p] != 5'd0) begin
                if (we_q && (waddr_q == fa[p])) begin
                    fh[p] = 1'b1;
                    fd[p] = wdata_q;
                end
                // Walk oldest to youngest so the youngest live match wins.
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (ent_live_q[rptr_q + PW'(i)] && (ent_reg_q[rptr_q + PW'(i)] == fa[p])) begin
                        fh[p] = 1'b1;
                        fd[p] = ent_data_q[rptr_q + PW'(i)];
                    end
                end
            end
        end
    end

    assign fwd_hit1    = fh[0];
    assign fwd_data1   = fd[0];
    assign fwd_hit2    = fh[1];
    assign fwd_data2   = fd[1];
    assign RegWrite    = we_q;
    assign WriteReg    = waddr_q;
    assign WriteData   = wdata_q;
    assign pipe_stall  = stall_q;
    assign pending_cnt = cnt_q;
endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed self-checking bench for reg_write_scheduler (DEPTH=4, MAX_WAIT=8).
module tb_reg_write_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mu_valid;
    logic [4:0]  mu_reg;
    logic [31:0] mu_data;
    logic        mu_ready;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  fwd_reg1, fwd_reg2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic        pipe_stall;
    logic [2:0]  pending_cnt;

    int vectors = 0;
    int miscompares = 0;

    reg_write_scheduler #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .mu_valid(mu_valid), .mu_reg(mu_reg), .mu_data(mu_data), .mu_ready(mu_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .pipe_stall(pipe_stall), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
        wb_we = we; wb_reg = r; wb_data = d;
    endtask

    task automatic mu(input logic v, input logic [4:0] r, input logic [31:0] d);
        mu_valid = v; mu_reg = r; mu_data = d;
    endtask

    initial begin
        rst = 1'b0;
        wb(0, 0, 0);
        mu(0, 0, 0);
        fwd_reg1 = 0; fwd_reg2 = 0;
        repeat (2) step();
        chk("rst_regwrite", 32'(RegWrite), 0);
        chk("rst_writereg", 32'(WriteReg), 0);
        chk("rst_writedata", WriteData, 0);
        chk("rst_stall", 32'(pipe_stall), 0);
        chk("rst_cnt", 32'(pending_cnt), 0);
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(mu_ready), 1);

        // Plain WB write and its one-cycle forwarding window
        wb(1, 5, 32'hA5);
        step();
        chk("wb_we", 32'(RegWrite), 1);
        chk("wb_reg", 32'(WriteReg), 5);
        chk("wb_data", WriteData, 32'hA5);
        fwd_reg1 = 5; #1;
        chk("wb_fwd_hit", 32'(fwd_hit1), 1);
        chk("wb_fwd_data", fwd_data1, 32'hA5);
        wb(0, 0, 0);
        step();
        chk("idle_we", 32'(RegWrite), 0);
        chk("idle_hold_reg", 32'(WriteReg), 5);
        chk("idle_fwd_hit", 32'(fwd_hit1), 0);
        chk("idle_fwd_data", fwd_data1, 0);

        // Two MU results queued behind WB, then drained in order
        wb(1, 9, 32'h90); mu(1, 3, 32'h11);
        step();
        chk("q_cnt1", 32'(pending_cnt), 1);
        mu(1, 4, 32'h22);
        step();
        chk("q_cnt2", 32'(pending_cnt), 2);
        fwd_reg1 = 9; fwd_reg2 = 4; #1;
        chk("q_fwd_out", fwd_data1, 32'h90);
        chk("q_fwd_fifo", fwd_data2, 32'h22);
        wb(0, 0, 0); mu(0, 0, 0);
        step();
        chk("q_pop1_reg", 32'(WriteReg), 3);
        chk("q_pop1_data", WriteData, 32'h11);
        chk("q_pop1_cnt", 32'(pending_cnt), 1);
        step();
        chk("q_pop2_reg", 32'(WriteReg), 4);
        chk("q_pop2_data", WriteData, 32'h22);
        chk("q_pop2_cnt", 32'(pending_cnt), 0);
        step();
        chk("q_idle_we", 32'(RegWrite), 0);

        // Kill of a queued entry by a later WB write
        mu(1, 7, 32'h70);
        step();
        mu(0, 0, 0);
        fwd_reg1 = 7; #1;
        chk("kill_pre_fwd", fwd_data1, 32'h70);
        wb(1, 7, 32'h99);
        step();
        chk("kill_wb_data", WriteData, 32'h99);
        chk("kill_cnt", 32'(pending_cnt), 1);
        chk("kill_fwd", fwd_data1, 32'h99);
        wb(0, 0, 0);
        step();
        chk("kill_dead_we", 32'(RegWrite), 0);
        chk("kill_dead_cnt", 32'(pending_cnt), 0);
        chk("kill_dead_fwd", 32'(fwd_hit1), 0);
        chk("kill_hold_data", WriteData, 32'h99);

        // Same-cycle MU and WB to one register: MU entry enqueued dead
        wb(1, 6, 32'h66); mu(1, 6, 32'h60);
        step();
        wb(0, 0, 0); mu(0, 0, 0);
        fwd_reg2 = 6; #1;
        chk("same_cnt", 32'(pending_cnt), 1);
        chk("same_fwd", fwd_data2, 32'h66);
        step();
        chk("same_dead_we", 32'(RegWrite), 0);
        chk("same_dead_cnt", 32'(pending_cnt), 0);

        // Fill under continuous WB, starvation stall, release
        wb(1, 1, 32'h1);
        for (int i = 0; i < 4; i++) begin
            mu(1, 5'(10 + i), 32'hA0 + 32'(i));
            step();
        end
        chk("full_cnt", 32'(pending_cnt), 4);
        chk("full_ready", 32'(mu_ready), 0);
        mu(1, 14, 32'hEE);
        step();
        mu(0, 0, 0);
        chk("full_reject_cnt", 32'(pending_cnt), 4);
        repeat (3) step();
        chk("stall_pre", 32'(pipe_stall), 0);
        step();
        chk("stall_set", 32'(pipe_stall), 1);
        wb(0, 0, 0);
        step();
        chk("stall_pop_reg", 32'(WriteReg), 10);
        chk("stall_pop_data", WriteData, 32'hA0);
        chk("stall_pop_cnt", 32'(pending_cnt), 3);
        chk("stall_still", 32'(pipe_stall), 1);
        chk("stall_ready", 32'(mu_ready), 1);
        wb(1, 1, 32'h1);
        step();
        chk("stall_clear", 32'(pipe_stall), 0);
        wb(0, 0, 0);
        repeat (3) step();
        chk("drain_reg", 32'(WriteReg), 13);
        chk("drain_data", WriteData, 32'hA3);
        chk("drain_cnt", 32'(pending_cnt), 0);

        // Youngest-match forwarding, reg-0 discard, reset mid-drain
        wb(1, 1, 32'h1);
        mu(1, 2, 32'hB);
        step();
        mu(1, 2, 32'hC);
        step();
        fwd_reg2 = 2; #1;
        chk("young_fwd", fwd_data2, 32'hC);
        mu(1, 0, 32'hDD);
        step();
        chk("zero_cnt", 32'(pending_cnt), 2);
        chk("zero_ready", 32'(mu_ready), 1);
        wb(0, 0, 0); mu(0, 0, 0);
        step();
        chk("pre_rst_data", WriteData, 32'hB);
        chk("pre_rst_cnt", 32'(pending_cnt), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_we", 32'(RegWrite), 0);
        chk("mid_rst_reg", 32'(WriteReg), 0);
        chk("mid_rst_data", WriteData, 0);
        chk("mid_rst_cnt", 32'(pending_cnt), 0);
        #2;
        rst = 1'b1;
        step();
        chk("post_rst_we", 32'(RegWrite), 0);
        chk("post_rst_cnt", 32'(pending_cnt), 0);
        chk("post_rst_fwd", 32'(fwd_hit2), 0);
        step();
        chk("post_rst_we2", 32'(RegWrite), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_write_scheduler.md
Name: reg_write_scheduler

Overview:
- Write-side initiator for the register file's single write port.
- Merges in-order WB-stage writes with out-of-order results from a long-latency unit (mult/div, load-miss return). The long-latency results are buffered in a small FIFO.
- Drives the register file write inputs from a registered output stage.
- Provides forwarding lookups for writes still pending, and requests a pipeline stall when buffered writes starve.

Parameters:
- DEPTH, 4, number of FIFO entries for long-latency results; power of 2, at least 2.
- MAX_WAIT, 8, consecutive cycles the FIFO head may go unissued before pipe_stall asserts; at least 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low.
- wb_we  in  1  WB-stage write enable.
- wb_reg  in  5  WB-stage destination register.
- wb_data  in  32  WB-stage write data.
- mu_valid  in  1  long-latency result valid.
- mu_reg  in  5  long-latency destination register.
- mu_data  in  32  long-latency result data.
- mu_ready  out  1  FIFO can accept a result.
- RegWrite  out  1  register file write enable (registered).
- WriteReg  out  5  register file write address (registered).
- WriteData  out  32  register file write data (registered).
- fwd_reg1  in  5  forwarding lookup address, port 1.
- fwd_reg2  in  5  forwarding lookup address, port 2.
- fwd_hit1  out  1  pending write found for fwd_reg1 (combinational).
- fwd_hit2  out  1  pending write found for fwd_reg2 (combinational).
- fwd_data1  out  32  forwarded data for fwd_reg1.
- fwd_data2  out  32  forwarded data for fwd_reg2.
- pipe_stall  out  1  request upstream to suppress wb_we (registered).
- pending_cnt  out  $clog2(DEPTH+1)  FIFO occupancy, dead entries included.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; all entries marked dead; wait counter cleared.
  - RegWrite, WriteReg, WriteData, pipe_stall and pending_cnt all 0.
  - mu_ready=1 once rst=1.
  - Reset mid-operation discards all pending writes, including the output stage.
- Issue selection, evaluated every cycle; result registered into the output stage, so latency is 1 cycle:
  1. wb_we=1 and wb_reg!=0: issue the WB write. WB always wins.
  2. Otherwise, FIFO head live: pop it and issue.
  3. Otherwise, FIFO head dead: pop it, RegWrite=0.
  4. Otherwise: RegWrite=0; WriteReg and WriteData hold their previous values.
- wb_we=1 with wb_reg=0 is treated as idle.
- Enqueue:
  - Accepted on mu_valid && mu_ready.
  - mu_ready = (pending_cnt < DEPTH). It is not raised by a same-cycle pop when full.
  - mu_reg=0: accepted and discarded, not stored.
- Ordering / kill rule:
  - When a WB write to register X issues, every FIFO entry with reg X is marked dead at the same edge.
  - An entry enqueued in that same cycle with reg X is enqueued dead, because a same-cycle MU result is defined as older than WB.
  - Dead entries are never written and never forwarded.
- Forwarding, combinational:
  - Search order: youngest live FIFO entry matching, then output stage (RegWrite=1 and WriteReg match).
  - No match, or lookup address 0: hit=0, data=0.
  - wb_* inputs are not forwarded; the pipeline forwarding unit covers them.
- Starvation counter and pipe_stall:
  - Counter increments each cycle the FIFO is non-empty and no pop occurs; clears on any pop or when the FIFO is empty.
  - pipe_stall is set on the edge where the counter reaches MAX_WAIT.
  - pipe_stall clears on the edge after the next pop.
  - While pipe_stall=1, upstream keeps wb_we=0. If wb_we=1 arrives anyway, WB still wins and the counter keeps saturating at MAX_WAIT.
- Pointers: wrap modulo DEPTH. Simultaneous push and pop: pending_cnt unchanged.

Test Plan:
- Reset, then wb_we=1, wb_reg=5, wb_data=0xA5 -> next cycle RegWrite=1, WriteReg=5, WriteData=0xA5; following idle cycle RegWrite=0; fwd_reg1=5 hits 0xA5 for exactly that one cycle.
- WB idle; push mu writes (3,0x11), (4,0x22) -> issued in order on consecutive cycles at 1-cycle latency; pending_cnt 2→1→0.
- Push (7,0x70); then WB writes 7=0x99 before the entry drains -> only 0x99 is written to R7; the dead entry pops with RegWrite=0; fwd_reg1=7 never returns 0x70 after the kill.
- wb_we=1 every cycle, push DEPTH mu results -> mu_ready=0 at pending_cnt=4; pipe_stall=1 after 8 unissued cycles; drop wb_we -> one entry pops; pipe_stall clears the edge after.
- Push (2,0xB), (2,0xC), fwd_reg2=2 -> fwd_data2=0xC; mu_reg=0 push accepted without changing pending_cnt; assert rst mid-drain -> all outputs 0 immediately, nothing further written.
